jk_bank_arbiter: RTL and testbench

Shares one bank of WIDTH JK flip-flop cells between NREQ requesters. Each requester issues a command in JK, SR, D or T form. The block arbitrates round-robin, translates the winning command into per-bit J/K drives and applies it to the bank. It also enforces SR semantics: bits with S=R=1 are held and flagged. It sits above the flip-flop conversion cells as the single writer of the shared state register.

---
 rtl/jk_bank_arbiter_pkg.sv | 21 ++
 rtl/jk_bank_arbiter_if.sv | 28 ++
 rtl/jk_cell_bank.sv | 42 ++++
 rtl/jk_bank_arbiter.sv | 166 ++++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/jk_bank_arbiter_pkg.sv
// Shared types for the JK bank arbiter: command forms and FSM states.
// Also provides the index-width helper used for pointer/winner vectors.
package jk_arb_pkg;

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_SR = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jk_bank_arbiter_if.sv
// Requester-side bundle of the JK bank arbiter.
// master = requesters, slave = arbiter.
interface jk_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);

    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     mode;
    logic [NREQ*WIDTH-1:0] a_bus;
    logic [NREQ*WIDTH-1:0] b_bus;
    logic                  err_clr;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [WIDTH-1:0]      q;
    logic                  sr_err;

    modport master (
        output req, mode, a_bus, b_bus, err_clr,
        input  gnt, busy, q, sr_err
    );

    modport slave (
        input  req, mode, a_bus, b_bus, err_clr,
        output gnt, busy, q, sr_err
    );

endinterface

// File: rtl/jk_cell_bank.sv
// WIDTH JK flip-flop cells sharing clock, async reset and an update enable.
// With en_i low every cell holds regardless of j/k.
module jk_cell_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] j_i,
    input  logic [WIDTH-1:0] k_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (en_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                unique case ({j_i[i], k_i[i]})
                    2'b00: q_d[i] = q_q[i];
                    2'b01: q_d[i] = 1'b0;
                    2'b10: q_d[i] = 1'b1;
                    2'b11: q_d[i] = ~q_q[i];
                    default: q_d[i] = q_q[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter owning a shared JK bank; translates JK/SR/D/T commands.
// Define JKARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module jk_bank_arbiter
    import jk_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    jk_bank_arbiter_if.slave bus
);

    localparam int PW = idx_w(NREQ);

    state_e            state_q;
    logic [NREQ-1:0]   gnt_q;
    mode_e             mode_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              sr_err_q;

    logic [WIDTH-1:0]  a_arr [NREQ];
    logic [WIDTH-1:0]  b_arr [NREQ];
    logic [1:0]        m_arr [NREQ];

    logic              any_req;
    logic [PW-1:0]     win;
    logic [WIDTH-1:0]  j_vec;
    logic [WIDTH-1:0]  k_vec;
    logic              apply;
    logic              sr_set;
    logic [WIDTH-1:0]  bank_q;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign a_arr[g] = bus.a_bus[g*WIDTH +: WIDTH];
        assign b_arr[g] = bus.b_bus[g*WIDTH +: WIDTH];
        assign m_arr[g] = bus.mode[2*g +: 2];
    end

    assign any_req = |bus.req;

`ifdef JKARB_FIXED_PRIO_EN
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) win = PW'(i);
        end
    end
`else
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    // Scan upward from ptr_q, wrapping at NREQ; first requester wins.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
            idx = sum[PW-1:0];
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif

    always_comb begin
        j_vec = '0;
        k_vec = '0;
        unique case (mode_q)
            MODE_JK: begin
                j_vec = a_q;
                k_vec = b_q;
            end
            MODE_SR: begin
                j_vec = a_q & ~b_q;
                k_vec = b_q & ~a_q;
            end
            MODE_D: begin
                j_vec = a_q;
                k_vec = ~a_q;
            end
            MODE_T: begin
                j_vec = a_q;
                k_vec = a_q;
            end
            default: begin
                j_vec = '0;
                k_vec = '0;
            end
        endcase
    end

    assign apply  = (state_q == ST_APPLY);
    assign sr_set = apply && (mode_q == MODE_SR) && |(a_q & b_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            mode_q   <= MODE_JK;
            a_q      <= '0;
            b_q      <= '0;
            sr_err_q <= 1'b0;
`ifndef JKARB_FIXED_PRIO_EN
            ptr_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q <= ST_APPLY;
                        gnt_q   <= NREQ'(1) << win;
                        mode_q  <= mode_e'(m_arr[win]);
                        a_q     <= a_arr[win];
                        b_q     <= b_arr[win];
`ifndef JKARB_FIXED_PRIO_EN
                        ptr_q   <= ptr_d;
`endif
                    end
                end
                ST_APPLY: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
            endcase
            // A new S=R=1 event outranks a simultaneous clear.
            if (sr_set) begin
                sr_err_q <= 1'b1;
            end else if (bus.err_clr) begin
                sr_err_q <= 1'b0;
            end
        end
    end

    jk_cell_bank #(
        .WIDTH (WIDTH)
    ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (apply),
        .j_i   (j_vec),
        .k_i   (k_vec),
        .q_o   (bank_q)
    );

    assign bus.gnt    = gnt_q;
    assign bus.busy   = apply;
    assign bus.q      = bank_q;
    assign bus.sr_err = sr_err_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: directed scenarios plus random requesters
// checked against a transaction-level model of the bank.
module tb_jk_bank_arbiter;

    logic clk;
    logic rst_n;

    jk_bank_arbiter_if #(.NREQ(4), .WIDTH(8)) bus ();

    jk_bank_arbiter #(
        .NREQ  (4),
        .WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total;
    int bad;

    logic [7:0] m_q;
    logic [3:0] m_gnt;
    logic       m_busy;
    logic       m_err;
    int         m_ptr;
    int         m_mode;
    logic [7:0] m_a;
    logic [7:0] m_b;
    bit         pend [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] next_q(input int md, input logic [7:0] q,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        case (md)
            0: return (q & ~b) | (~q & a);
            1: return (q | (a & ~b)) & ~(b & ~a);
            2: return a;
            default: return q ^ a;
        endcase
    endfunction

    task automatic model_reset();
        m_q    = '0;
        m_gnt  = '0;
        m_busy = 1'b0;
        m_err  = 1'b0;
        m_ptr  = 0;
    endtask

    task automatic model_step();
        int w;
        int i;
        if (m_busy) begin
            m_q = next_q(m_mode, m_q, m_a, m_b);
            if (m_mode == 1 && (m_a & m_b) != 0) m_err = 1'b1;
            else if (bus.err_clr) m_err = 1'b0;
            m_busy = 1'b0;
            m_gnt  = '0;
        end else begin
            if (bus.err_clr) m_err = 1'b0;
            if (bus.req != 0) begin
                w = -1;
                for (int k = 0; k < 4; k++) begin
`ifdef JKARB_FIXED_PRIO_EN
                    i = k;
`else
                    i = (m_ptr + k) % 4;
`endif
                    if (w < 0 && bus.req[i]) w = i;
                end
                m_mode = int'(bus.mode[2*w +: 2]);
                m_a    = bus.a_bus[8*w +: 8];
                m_b    = bus.b_bus[8*w +: 8];
                m_gnt  = 4'b0001 << w;
                m_busy = 1'b1;
                m_ptr  = (w + 1) % 4;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        check("gnt", bus.gnt, m_gnt);
        check("busy", bus.busy, m_busy);
        check("q", bus.q, m_q);
        check("sr_err", bus.sr_err, m_err);
    endtask

    task automatic drive(input int i, input int md, input logic [7:0] a,
                         input logic [7:0] b);
        bus.req[i]        = 1'b1;
        bus.mode[2*i +: 2] = 2'(md);
        bus.a_bus[8*i +: 8] = a;
        bus.b_bus[8*i +: 8] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_gnt", bus.gnt, 4'b0000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_q", bus.q, 8'h00);
        check("rst_err", bus.sr_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        bus.req     = '0;
        bus.mode    = '0;
        bus.a_bus   = '0;
        bus.b_bus   = '0;
        bus.err_clr = 1'b0;
        rst_n       = 1'b1;
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        @(negedge clk);
        do_reset();

        drive(0, 2, 8'hA5, 8'h00);
        tick();
        check("d_gnt", bus.gnt, 4'b0001);
        bus.req[0] = 1'b0;
        tick();
        check("d_q", bus.q, 8'hA5);

        drive(2, 3, 8'h0F, 8'h00);
        tick();
        check("t_gnt", bus.gnt, 4'b0100);
        bus.req[2] = 1'b0;
        tick();
        check("t_q", bus.q, 8'hAA);
        check("t_gnt_off", bus.gnt, 4'b0000);

        drive(1, 1, 8'hF0, 8'h3C);
        tick();
        bus.req[1] = 1'b0;
        tick();
        check("sr_q", bus.q, 8'hE2);
        check("sr_err_set", bus.sr_err, 1'b1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check("sr_err_clr", bus.sr_err, 1'b0);

        do_reset();
        for (int i = 0; i < 4; i++)
            drive(i, int'($urandom_range(3)), 8'($urandom), 8'($urandom));
        for (int g = 0; g < 4; g++) begin
            tick();
            check("rr_gnt", bus.gnt, 4'b0001 << g);
            bus.req = bus.req & ~bus.gnt;
            tick();
        end

`ifdef JKARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) drive(i, 2, 8'($urandom), 8'h00);
        repeat (3) begin
            tick();
            check("fp_gnt", bus.gnt, 4'b0001);
            tick();
        end
        bus.req = '0;
        tick();
`endif

        repeat (600) begin
            for (int i = 0; i < 4; i++) begin
                if (pend[i] && bus.gnt[i]) begin
                    pend[i]    = 1'b0;
                    bus.req[i] = 1'b0;
                end else if (!pend[i] && $urandom_range(2) == 0) begin
                    pend[i] = 1'b1;
                    drive(i, int'($urandom_range(3)), 8'($urandom),
                          8'($urandom));
                end
            end
            bus.err_clr = ($urandom_range(7) == 0);
            tick();
        end
        bus.req     = '0;
        bus.err_clr = 1'b0;
        for (int i = 0; i < 4; i++) pend[i] = 1'b0;
        tick();
        tick();

        do_reset();
        drive(0, 0, 8'hFF, 8'h00);
        tick();
        check("rb_busy_hi", bus.busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rb_gnt", bus.gnt, 4'b0000);
        check("rb_busy", bus.busy, 1'b0);
        model_reset();
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rb_q", bus.q, 8'h00);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
